// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame path: FSM states, error codes and
// default field widths used by both the serializer and the receiver.
package serial_frame_receiver_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 4;
   localparam int CNT_W_DEF  = 8;

   typedef enum logic [2:0] {
      S_RESYNC  = 3'd0,
      S_IDLE    = 3'd1,
      S_SHIFT   = 3'd2,
      S_END     = 3'd3,
      S_OVERRUN = 3'd4
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_SHORT = 2'b01;
   localparam logic [1:0] ERR_LONG  = 2'b10;

   // Width needed to hold a bit count from 0 up to and including n.
   function automatic int count_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/serial_frame_regfile.sv
// 2**ADDR_W x DATA_W register file: one write port, one registered read port,
// asynchronous clear of every entry.
module serial_frame_regfile #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the array is cleared by reset, so it must be flops rather than a
   // RAM macro; acceptable at this depth and required for a known power-up state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_data <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_addr] <= wr_data;
         end
         // NOTE: non-blocking update means a same-cycle read of wr_addr sees
         // the old contents (read-before-write).
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/serial_frame_receiver.sv
// Rebuilds {addr,data} words from the serializer's bit stream, checks frame
// length, commits good words to the register file and the parallel bus.
module serial_frame_receiver
   import serial_frame_receiver_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ser_frame,
   input  logic              ser_data,
   output logic              out_clk,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              frame_err,
   output logic [1:0]        err_code,
   output logic [CNT_W-1:0]  frame_cnt,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int FRAME_W   = ADDR_W + DATA_W;
   localparam int BIT_CNT_W = count_width(FRAME_W);
   localparam logic [BIT_CNT_W-1:0] LAST_CNT = BIT_CNT_W'(FRAME_W - 1);

   state_t               state;
   logic [FRAME_W-1:0]   shift_reg;
   logic [BIT_CNT_W-1:0] bit_cnt;

   logic [ADDR_W-1:0] word_addr;
   logic [DATA_W-1:0] word_data;
   logic              commit;

   assign word_addr = shift_reg[FRAME_W-1:DATA_W];
   assign word_data = shift_reg[DATA_W-1:0];
   // Memory write shares the commit edge with the output registers.
   assign commit    = (state == S_END) && !ser_frame;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_RESYNC;
         shift_reg <= '0;
         bit_cnt   <= '0;
         out_clk   <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         frame_err <= 1'b0;
         err_code  <= ERR_NONE;
         frame_cnt <= '0;
      end else begin
         // NOTE: strobes default low every cycle so each branch only raises them;
         // this keeps them single-cycle without per-state clearing.
         out_clk   <= 1'b0;
         frame_err <= 1'b0;

         case (state)
            S_RESYNC: begin
               if (!ser_frame) begin
                  state <= S_IDLE;
               end
            end

            S_IDLE: begin
               if (ser_frame) begin
                  shift_reg <= {shift_reg[FRAME_W-2:0], ser_data};
                  bit_cnt   <= BIT_CNT_W'(1);
                  state     <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               if (ser_frame) begin
                  shift_reg <= {shift_reg[FRAME_W-2:0], ser_data};
                  bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                  if (bit_cnt == LAST_CNT) begin
                     state <= S_END;
                  end
               end else begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_SHORT;
                  bit_cnt   <= '0;
                  state     <= S_IDLE;
               end
            end

            S_END: begin
               if (!ser_frame) begin
                  out_clk   <= 1'b1;
                  out_addr  <= word_addr;
                  out_data  <= word_data;
                  frame_cnt <= frame_cnt + CNT_W'(1);
                  bit_cnt   <= '0;
                  state     <= S_IDLE;
               end else begin
                  state <= S_OVERRUN;
               end
            end

            S_OVERRUN: begin
               if (!ser_frame) begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_LONG;
                  bit_cnt   <= '0;
                  state     <= S_IDLE;
               end
            end

            default: state <= S_RESYNC;
         endcase
      end
   end

   serial_frame_regfile #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (commit),
      .wr_addr (word_addr),
      .wr_data (word_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule
